// File: rtl/fp_pkg.sv
// fp_pkg -- constants and types shared by the floating-point adder path.
//   FP_EXP_W / FP_MANT_W : default exponent and stored-fraction widths
//   norm_state_t         : left_normalizer FSM states
package fp_pkg;

    localparam int unsigned FP_EXP_W  = 3;
    localparam int unsigned FP_MANT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } norm_state_t;

endpackage

// File: rtl/round_nearest_even.sv
// round_nearest_even -- rounds a fraction that has had exactly one bit
// shifted out. With a single dropped bit the only inexact case is an exact
// tie, so the fraction is incremented only when it is odd.
//   frac      : kept fraction bits (hidden bit excluded)
//   round_bit : the bit that was shifted out
//   rounded   : rounded fraction
//   carry_out : increment overflowed the fraction (result needs renormalizing)
module round_nearest_even #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] frac,
    input  logic         round_bit,
    output logic [W-1:0] rounded,
    output logic         carry_out
);

    logic inc;

    assign inc = round_bit & frac[0];
    assign {carry_out, rounded} = {1'b0, frac} + {{W{1'b0}}, inc};

endmodule

// File: rtl/left_normalizer.sv
// left_normalizer -- normalizes a raw adder sum {carry, hidden, fraction}.
// A carry is corrected by one right shift; a missing hidden bit by
// repeated left shifts, one per clock. Flags overflow and underflow.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : input handshake (ready only when idle)
//   in_sign, in_exp, in_sum : raw sum fields
//   out_valid / out_ready : output handshake, result held until taken
//   out_sign, out_exp, out_mant, ovf, unf : normalized result and flags
// Build option: define NORM_ROUND_EN to round the carry right-shift to
// nearest-even instead of truncating the dropped bit.
module left_normalizer
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W  = FP_EXP_W,
    parameter int unsigned MANT_W = FP_MANT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W+1:0] in_sum,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [MANT_W-1:0] out_mant,
    output logic              ovf,
    output logic              unf
);

    localparam int unsigned      SUM_W   = MANT_W + 2;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    norm_state_t       state, state_nx;
    logic              sign_r, sign_nx;
    logic [EXP_W-1:0]  exp_r, exp_nx;
    logic [SUM_W-1:0]  sum_r, sum_nx;

    logic              load;
    logic              res_sign, res_ovf, res_unf;
    logic [EXP_W-1:0]  res_exp;
    logic [MANT_W-1:0] res_mant;

    logic              carry, hidden;
    logic [EXP_W-1:0]  exp_inc;
    logic [MANT_W-1:0] rnd_mant;
    logic              rnd_co;

    assign carry   = sum_r[SUM_W-1];
    assign hidden  = sum_r[SUM_W-2];
    assign exp_inc = exp_r + EXP_W'(1);

`ifdef NORM_ROUND_EN
    round_nearest_even #(
        .W (MANT_W)
    ) u_rne (
        .frac      (sum_r[MANT_W:1]),
        .round_bit (sum_r[0]),
        .rounded   (rnd_mant),
        .carry_out (rnd_co)
    );
`else
    assign rnd_mant = sum_r[MANT_W:1];
    assign rnd_co   = 1'b0;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        state_nx = state;
        sign_nx  = sign_r;
        exp_nx   = exp_r;
        sum_nx   = sum_r;
        load     = 1'b0;
        res_sign = sign_r;
        res_exp  = exp_r;
        res_mant = sum_r[MANT_W-1:0];
        res_ovf  = 1'b0;
        res_unf  = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    sign_nx  = in_sign;
                    exp_nx   = in_exp;
                    sum_nx   = in_sum;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                load     = 1'b1;
                state_nx = DONE;
                if (sum_r == '0) begin
                    res_sign = 1'b0;
                    res_exp  = '0;
                    res_mant = '0;
                end else if (carry) begin
                    if (exp_r == EXP_MAX) begin
                        res_ovf  = 1'b1;
                        res_exp  = EXP_MAX;
                        res_mant = '0;
                    end else if (rnd_co) begin
                        // Rounding wrapped the fraction: value is 2.0 at
                        // exp_inc, renormalize once more.
                        res_mant = '0;
                        if (exp_inc == EXP_MAX) begin
                            res_ovf = 1'b1;
                            res_exp = EXP_MAX;
                        end else begin
                            res_exp = exp_inc + EXP_W'(1);
                        end
                    end else begin
                        res_exp  = exp_inc;
                        res_mant = rnd_mant;
                    end
                end else if (hidden) begin
                    // already normalized, defaults hold
                end else if (exp_r == '0) begin
                    res_unf  = 1'b1;
                    res_sign = 1'b0;
                    res_exp  = '0;
                    res_mant = '0;
                end else begin
                    load     = 1'b0;
                    state_nx = SHIFT;
                    sum_nx   = sum_r << 1;
                    exp_nx   = exp_r - EXP_W'(1);
                end
            end
            DONE: begin
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sign_r   <= 1'b0;
            exp_r    <= '0;
            sum_r    <= '0;
            out_sign <= 1'b0;
            out_exp  <= '0;
            out_mant <= '0;
            ovf      <= 1'b0;
            unf      <= 1'b0;
        end else begin
            state  <= state_nx;
            sign_r <= sign_nx;
            exp_r  <= exp_nx;
            sum_r  <= sum_nx;
            if (load) begin
                out_sign <= res_sign;
                out_exp  <= res_exp;
                out_mant <= res_mant;
                ovf      <= res_ovf;
                unf      <= res_unf;
            end
        end
    end

endmodule

// File: tb/tb_left_normalizer.sv
module tb_left_normalizer;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       in_sign;
    logic [2:0] in_exp;
    logic [5:0] in_sum;
    logic       out_valid;
    logic       out_ready;
    logic       out_sign;
    logic [2:0] out_exp;
    logic [3:0] out_mant;
    logic       ovf;
    logic       unf;

    int vectors;
    int miscompares;

    left_normalizer #(
        .EXP_W  (3),
        .MANT_W (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_sum    (in_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_exp   (out_exp),
        .out_mant  (out_mant),
        .ovf       (ovf),
        .unf       (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Offer one sum, measure edges (accept edge = 1) until out_valid, check
    // the result. Leaves the block in DONE with out_ready low.
    task automatic run(input string tag, input logic s, input logic [2:0] e,
                       input logic [5:0] sm, input int lat_exp,
                       input logic es, input logic [2:0] ee, input logic [3:0] em,
                       input logic eo, input logic eu);
        int lat;
        @(negedge clk);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = e;
        in_sum   = sm;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(lat_exp));
        chk({tag, "_sign"}, 32'(out_sign), 32'(es));
        chk({tag, "_exp"}, 32'(out_exp), 32'(ee));
        chk({tag, "_mant"}, 32'(out_mant), 32'(em));
        chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
        chk({tag, "_unf"}, 32'(unf), 32'(eu));
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_released_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_released_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_sum    = '0;
        out_ready = 1'b0;

        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_exp", 32'(out_exp), 32'd0);
        chk("rst_out_mant", 32'(out_mant), 32'd0);
        chk("rst_flags", 32'({ovf, unf, out_sign}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // already normalized
        run("norm", 1'b0, 3'd3, 6'b010110, 2, 1'b0, 3'd3, 4'b0110, 1'b0, 1'b0);
        consume("norm");

        // carry: tie case, fraction 0101 is odd so rounding goes up
`ifdef NORM_ROUND_EN
        run("carry", 1'b1, 3'd3, 6'b101011, 2, 1'b1, 3'd4, 4'b0110, 1'b0, 1'b0);
`else
        run("carry", 1'b1, 3'd3, 6'b101011, 2, 1'b1, 3'd4, 4'b0101, 1'b0, 1'b0);
`endif
        consume("carry");

        // carry with all-ones fraction: rounding wraps to exp+2
`ifdef NORM_ROUND_EN
        run("carry_wrap", 1'b0, 3'd3, 6'b111111, 2, 1'b0, 3'd5, 4'b0000, 1'b0, 1'b0);
        consume("carry_wrap");
        run("carry_wrap_ovf", 1'b0, 3'd6, 6'b111111, 2, 1'b0, 3'd7, 4'b0000, 1'b1, 1'b0);
`else
        run("carry_wrap", 1'b0, 3'd3, 6'b111111, 2, 1'b0, 3'd4, 4'b1111, 1'b0, 1'b0);
        consume("carry_wrap");
        run("carry_wrap_ovf", 1'b0, 3'd6, 6'b111111, 2, 1'b0, 3'd7, 4'b1111, 1'b0, 1'b0);
`endif
        consume("carry_wrap_ovf");

        // three left shifts
        run("shift3", 1'b0, 3'd5, 6'b000011, 5, 1'b0, 3'd2, 4'b1000, 1'b0, 1'b0);
        consume("shift3");

        // four left shifts
        run("shift4", 1'b1, 3'd6, 6'b000001, 6, 1'b1, 3'd2, 4'b0000, 1'b0, 1'b0);
        consume("shift4");

        // zero sum clears the sign
        run("zero", 1'b1, 3'd6, 6'b000000, 2, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0);
        consume("zero");

        // carry at the top exponent
        run("ovf", 1'b0, 3'd7, 6'b100000, 2, 1'b0, 3'd7, 4'b0000, 1'b1, 1'b0);
        consume("ovf");

        // left shift needed at exp 0
        run("unf", 1'b1, 3'd0, 6'b000100, 2, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b1);
        consume("unf");

        // exponent runs out after one shift
        run("unf_late", 1'b1, 3'd1, 6'b000011, 3, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b1);
        consume("unf_late");

        // stall: result held while out_ready low, new offers ignored
        run("stall", 1'b1, 3'd5, 6'b011001, 2, 1'b1, 3'd5, 4'b1001, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_sign  = 1'b0;
            in_exp   = 3'd2;
            in_sum   = 6'b000110;
            @(posedge clk);
            #1;
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_fields", 32'({out_sign, out_exp, out_mant}), 32'({1'b1, 3'd5, 4'b1001}));
        end
        @(negedge clk);
        in_valid = 1'b0;
        consume("stall");

        // reset in the middle of a shift sequence
        @(negedge clk);
        in_valid = 1'b1;
        in_sign  = 1'b1;
        in_exp   = 3'd6;
        in_sum   = 6'b000001;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_pre_valid", 32'(out_valid), 32'd0);
        chk("midrst_pre_busy", 32'(in_ready), 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_fields", 32'({out_sign, out_exp, out_mant, ovf, unf}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("midrst_discarded", 32'(out_valid), 32'd0);
        chk("midrst_idle", 32'(in_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/left_normalizer.md
LEFT_NORMALIZER -- requirements
Module: left_normalizer

Interface
REQ-001 SHALL have parameter EXP_W, default 3, exponent width.
REQ-002 SHALL have parameter MANT_W, default 4, stored fraction width (hidden bit excluded).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, raw sum offered.
REQ-006 SHALL have port in_ready, output, 1, block can accept a sum.
REQ-007 SHALL have port in_sign, input, 1, sign of the raw sum.
REQ-008 SHALL have port in_exp, input, EXP_W, exponent of the larger operand.
REQ-009 SHALL have port in_sum, input, MANT_W+2, raw adder output: {carry, hidden, fraction}.
REQ-010 SHALL have port out_valid, output, 1, normalized result held.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-012 SHALL have ports out_sign (1), out_exp (EXP_W) and out_mant (MANT_W), outputs, normalized result fields.
REQ-013 SHALL have ports ovf and unf, outputs, 1 each, overflow and underflow flags, valid with out_valid.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE, so no new sum is accepted while a result is pending.
REQ-016 SHALL, in IDLE with in_valid=1, register sign/exp/sum at that edge and enter SHIFT.
REQ-017 SHALL evaluate one SHIFT cycle at a time, in priority order:
- sum==0: exp=0, mant=0, sign=0, go DONE.
- carry bit set: sum>>1, exp+1, go DONE.
- hidden bit set: go DONE.
- otherwise: sum<<1, exp-1, stay in SHIFT.
REQ-018 SHALL, on carry with exp==2^EXP_W-1, set ovf=1, output exp=all-ones, mant=0 and go DONE.
REQ-019 SHALL, when a left shift is required with exp==0, set unf=1, output exp=0, mant=0, sign=0 and go DONE.
REQ-020 SHALL assert out_valid throughout DONE, with outputs registered and stable.
REQ-021 SHALL give these latencies from the accepting edge:
- already normalized, carry or zero: out_valid after 2 edges.
- each left shift: +1 edge, so a 4-shift case takes 6.
REQ-022 SHALL hold outputs and out_valid while out_ready=0 in DONE, and return to IDLE at the edge where out_ready=1.
REQ-023 SHALL take out_mant from sum[MANT_W-1:0] once normalized.

Reset
REQ-024 SHALL, while rst_n=0, asynchronously force state=IDLE, out_valid=0, out_sign=0, out_exp=0, out_mant=0, ovf=0, unf=0, and hence in_ready=1.
REQ-025 SHALL, on reset asserted during SHIFT or DONE, discard the operation with no output produced.

Configuration
REQ-026 SHALL, with NORM_ROUND_EN defined, round the carry right-shift to nearest-even using the dropped bit; a rounding carry-out renormalizes (mant=0, exp+1) and applies the REQ-018 overflow check.
REQ-027 SHALL, without NORM_ROUND_EN, truncate the dropped bit; latency is identical in both builds.

Structure
REQ-028 SHALL place the default EXP_W/MANT_W constants and the FSM state enum in the shared fp_pkg package, shared with the adder path.
REQ-029 SHALL keep the rounding logic in one sub-module, round_nearest_even, instantiated only when NORM_ROUND_EN is defined; no other sub-modules.

Verification
REQ-030 SHALL check: sum=010110, exp=3 -> mant=0110, exp=3, out_valid 2 edges after accept.
REQ-031 SHALL check: sum=101011, exp=3 -> mant=0101, exp=4 truncated; mant=0110, exp=4 with NORM_ROUND_EN.
REQ-032 SHALL check: sum=000011, exp=5 -> mant=1000, exp=2, out_valid 5 edges after accept.
REQ-033 SHALL check: sum=000000, exp=6, sign=1 -> sign=0, exp=0, mant=0, ovf=0, unf=0.
REQ-034 SHALL check: sum=100000, exp=7 -> ovf=1, exp=7, mant=0; and sum=000100, exp=0 -> unf=1, result 0.
REQ-035 SHALL check: out_ready=0 for 10 cycles keeps outputs stable and in_ready=0; rst_n pulsed low mid-SHIFT -> all outputs 0 and in_ready=1 immediately.
